// File: rtl/kbd_mailbox_pkg.sv
// kbd_mailbox_pkg: shared constants and types for the keyboard code mailbox
package kbd_mailbox_pkg;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam int ST_RDY = 0;
  localparam int ST_BRK = 1;
  localparam int ST_EXT = 2;
  localparam int ST_OVF = 3;
  localparam int ST_ERR = 4;
  localparam int ST_SEQ = 5;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} pfx_state_t;
endpackage

// File: rtl/kbd_code_fifo.sv
// kbd_code_fifo: synchronous FIFO with flush and count; a push while full succeeds when a pop frees a slot the same cycle
module kbd_code_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 10,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // pointers wrap naturally; count only tracks accepted pushes and real pops
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset: flushed entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/kbd_code_mailbox.sv
// kbd_code_mailbox: folds E0/F0 prefixes into flags, queues codes and presents them under a toggle-ack handshake
module kbd_code_mailbox
  import kbd_mailbox_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_valid,
  input  logic [7:0]       scan_byte,
  input  logic             ack_toggle,
  input  logic             clear,
  output logic [7:0]       key_code,
  output logic [7:0]       code_status,
  output logic [LVL_W-1:0] fifo_level
);
  pfx_state_t state, nxt;
  entry_t new_e, head;
  logic is_pfx, push, pop, full, empty, ack, ack_prev;
  logic rdy, brk, ext, ovf, ack_err;
  logic [2:0] seq;
  assign is_pfx = scan_byte == PFX_EXT || scan_byte == PFX_BRK;
  assign push = scan_valid && !is_pfx && !clear;
  assign pop = !rdy && !empty && !clear;
  assign ack = ack_toggle != ack_prev;
  assign new_e = '{ext: state == GOT_E0 || state == GOT_E0F0,
                   brk: state == GOT_F0 || state == GOT_E0F0,
                   code: scan_byte};
  kbd_code_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
    .clk(clk),
    .rst(reset),
    .clear(clear),
    .push(push),
    .pop(pop),
    .din(new_e),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_level)
  );
  // prefix tracking: a break prefix after nothing blocks a later E0 from marking ext
  always_comb begin
    nxt = !scan_valid ? state :
          !is_pfx ? IDLE :
          state == IDLE ? (scan_byte == PFX_EXT ? GOT_E0 : GOT_F0) :
          (state == GOT_E0 && scan_byte == PFX_BRK) ? GOT_E0F0 : state;
  end
  // status byte layout seen by software
  always_comb begin
    code_status = '0;
    code_status[ST_RDY] = rdy;
    code_status[ST_BRK] = brk;
    code_status[ST_EXT] = ext;
    code_status[ST_OVF] = ovf;
    code_status[ST_ERR] = ack_err;
    code_status[ST_SEQ +: 3] = seq;
  end
  // presentation register, handshake and sticky error flags
  always_ff @(posedge clk) begin
    ack_prev <= ack_toggle;
    if (reset || clear) begin
      state <= IDLE;
      rdy <= 1'b0;
      brk <= 1'b0;
      ext <= 1'b0;
      key_code <= '0;
      seq <= '0;
      ovf <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state <= nxt;
      if (pop) begin
        rdy <= 1'b1;
        brk <= head.brk;
        ext <= head.ext;
        key_code <= head.code;
        seq <= seq + 3'd1;
      end else if (ack) rdy <= 1'b0;
      if (ack && !rdy) ack_err <= 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kbd_code_mailbox.sv
// tb_kbd_code_mailbox: scoreboard bench with directed scenarios and a randomized phase
module tb_kbd_code_mailbox;
  localparam int DEPTH = 8;
  logic clk = 0, reset = 1, scan_valid = 0, ack_toggle = 0, clear = 0;
  logic [7:0] scan_byte = 0, key_code, code_status;
  logic [3:0] fifo_level;
  int checks = 0, errors = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  int out = 0, nseq = 0;
  bit ext_p = 0, brk_p = 0, rdy_q = 0;

  kbd_code_mailbox #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .scan_valid(scan_valid),
    .scan_byte(scan_byte),
    .ack_toggle(ack_toggle),
    .clear(clear),
    .key_code(key_code),
    .code_status(code_status),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model;
    exp_q.delete();
    out = 0;
    nseq = 0;
    ext_p = 0;
    brk_p = 0;
  endtask

  // reference: mailbox holds DEPTH queued codes plus one presented code;
  // each accepted code is the next load, so its seq is its ordinal mod 8
  task automatic drive_scan(input logic [7:0] b);
    scan_valid = 1;
    scan_byte = b;
    if (b == 8'hE0) begin
      if (!brk_p) ext_p = 1;
    end else if (b == 8'hF0) brk_p = 1;
    else begin
      if (out < DEPTH + 1) begin
        nseq++;
        out++;
        exp_q.push_back({3'(nseq % 8), ext_p, brk_p, b});
      end
      ext_p = 0;
      brk_p = 0;
    end
  endtask

  task automatic scan(input logic [7:0] b);
    drive_scan(b);
    tick;
    scan_valid = 0;
  endtask

  task automatic ack;
    ack_toggle = ~ack_toggle;
    out--;
    tick;
    tick;
  endtask

  task automatic do_clear;
    clear = 1;
    flush_model;
    tick;
    clear = 0;
  endtask

  // monitor: every new presentation must match the oldest expected code
  always @(negedge clk) begin
    if (!reset && code_status[0] && !rdy_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load got key_code %h expected no load", key_code);
      end else begin
        mon_e = exp_q.pop_front();
        chk("load", {code_status[7:5], code_status[2:1], key_code}, mon_e);
      end
    end
    rdy_q = code_status[0];
  end

  initial begin
    logic [7:0] b;
    int r;
    tick;
    tick;
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle", {key_code, code_status, fifo_level}, 0);
      tick;
    end
    scan(8'h1C);
    tick;
    chk("single_key", key_code, 8'h1C);
    chk("single_status", code_status, 8'h21);
    ack_toggle = ~ack_toggle;
    out--;
    tick;
    chk("ack_status", code_status, 8'h20);
    chk("ack_hold_key", key_code, 8'h1C);
    scan(8'hE0);
    scan(8'hF0);
    scan(8'h74);
    tick;
    chk("ext_brk_key", key_code, 8'h74);
    chk("ext_brk_status", code_status, 8'h47);
    ack;
    scan(8'hF0);
    scan(8'h1C);
    tick;
    chk("brk_key", key_code, 8'h1C);
    chk("brk_status", code_status, 8'h63);
    ack;
    do_clear;
    for (int i = 0; i < 10; i++) scan(8'(8'h11 + i));
    chk("ovf_key", key_code, 8'h11);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_status", code_status, 8'h29);
    for (int i = 0; i < 9; i++) ack;
    chk("drain_level", fifo_level, 0);
    chk("drain_status", code_status, 8'h28);
    chk("drain_key", key_code, 8'h19);
    tick;
    do_clear;
    for (int i = 0; i < 9; i++) scan(8'(8'h21 + i));
    chk("full_level", fifo_level, 8);
    chk("full_status", code_status, 8'h21);
    ack_toggle = ~ack_toggle;
    out--;
    tick;
    chk("full_ack_status", code_status, 8'h20);
    scan(8'h2A);
    chk("pushpop_level", fifo_level, 8);
    chk("pushpop_status", code_status, 8'h41);
    tick;
    tick;
    do_clear;
    tick;
    ack_toggle = ~ack_toggle;
    tick;
    chk("ack_err", code_status, 8'h10);
    ack_toggle = ~ack_toggle;
    clear = 1;
    flush_model;
    tick;
    clear = 0;
    chk("clear_all", {key_code, code_status, fifo_level}, 0);
    tick;
    chk("no_spurious_ack", code_status, 8'h00);
    scan(8'h33);
    tick;
    chk("post_clear_load", code_status, 8'h21);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("held_rdy", code_status, 8'h21);
    end
    ack;
    scan(8'hE0);
    do_clear;
    scan(8'h74);
    tick;
    chk("clear_prefix_key", key_code, 8'h74);
    chk("clear_prefix_status", code_status, 8'h21);
    ack;
    scan(8'hE0);
    reset = 1;
    flush_model;
    tick;
    reset = 0;
    scan(8'h74);
    tick;
    chk("reset_prefix_key", key_code, 8'h74);
    chk("reset_prefix_status", code_status, 8'h21);
    ack;
    for (int i = 0; i < 1500; i++) begin
      if (code_status[0] && $urandom_range(0, 2) == 0) begin
        ack_toggle = ~ack_toggle;
        out--;
      end
      if ($urandom_range(0, 9) < 5 && out < DEPTH) begin
        r = $urandom_range(0, 9);
        b = 8'($urandom_range(0, 255));
        if (b == 8'hE0 || b == 8'hF0) b = 8'hE1;
        drive_scan(r < 2 ? 8'hE0 : r < 4 ? 8'hF0 : b);
      end
      tick;
      scan_valid = 0;
    end
    for (int i = 0; i < 300 && (out > 0 || exp_q.size() > 0); i++) begin
      if (code_status[0]) begin
        ack_toggle = ~ack_toggle;
        out--;
      end
      tick;
    end
    tick;
    chk("random_out", out, 0);
    chk("random_queue", exp_q.size(), 0);
    chk("random_sticky", code_status[4:3], 0);
    chk("random_level", fifo_level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kbd_code_mailbox.md
Name: kbd_code_mailbox

Overview:
Sequences the PS/2 keyboard datapath into the HPS-visible keyboard_pio and code_rdy_pio inputs. Accepts raw scan bytes from the PS/2 receiver and folds E0/F0 prefixes into flags. Buffers completed codes in a small FIFO and presents them one at a time. Uses a toggle-ack handshake driven by an HPS-owned LED PIO bit, so the software never loses or double-reads a key event.

Parameters:
FIFO_DEPTH, 8, number of buffered codes excluding the presented one; must be a power of two and at least 2.
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level (derived, not overridden).

Ports:
clk  in  1  system clock; same domain as the PIO slaves.
reset  in  1  synchronous, active-high.
scan_valid  in  1  one-cycle strobe; scan_byte valid.
scan_byte  in  8  raw PS/2 scan byte.
ack_toggle  in  1  HPS ack; each level change acknowledges the presented code.
clear  in  1  synchronous flush (pushbutton-derived).
key_code  out  8  presented code, to keyboard_pio_external_connection_export.
code_status  out  8  to code_rdy_pio_external_connection_export: [0] rdy, [1] brk, [2] ext, [3] overflow (sticky), [4] ack_err (sticky), [7:5] seq.
fifo_level  out  LVL_W  queued entries, excluding the presented one.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: key_code=0, code_status=0, fifo_level=0, FSM=IDLE, FIFO empty, ack_prev<=ack_toggle.
- Prefix FSM, advancing only on scan_valid:
  - IDLE: E0->GOT_E0; F0->GOT_F0; any other byte -> push {ext=0,brk=0,code}.
  - GOT_E0: E0->GOT_E0; F0->GOT_E0F0; other -> push {1,0,code}, IDLE.
  - GOT_F0: E0/F0->GOT_F0; other -> push {0,1,code}, IDLE.
  - GOT_E0F0: E0/F0 -> stay; other -> push {1,1,code}, IDLE.
  - E1 and all other bytes are ordinary codes.
- FIFO entry: 10 bits {ext,brk,code}.
- Push timing: a push in cycle N writes at the end of N; the entry is visible in fifo_level in N+1.
- Presentation:
  - When rdy=0 and the FIFO is non-empty, the head is popped into the output register.
  - rdy=1, brk, ext and key_code update together.
  - seq increments mod 8 on each load.
  - Scan byte in N on an empty mailbox -> rdy=1 in N+2.
- Ack detect: ack = (ack_toggle != ack_prev); ack_prev is registered every cycle.
  - Ack with rdy=1 -> rdy=0 next cycle; key_code, brk, ext and seq hold their values.
  - After rdy falls, rdy stays 0 for at least one full cycle before the next load (ack at M -> earliest next rdy=1 at M+2).
  - Ack with rdy=0 -> set ack_err; no other effect.
- Full FIFO:
  - Push while full with no same-cycle pop -> entry dropped, overflow set, level stays FIFO_DEPTH.
  - Push and pop in the same cycle while full -> both succeed, no overflow.
- Push into an empty FIFO in the same cycle a load is eligible: the load waits one cycle; there is no bypass.
- clear (takes priority over everything except reset):
  - Flushes the FIFO and sets FSM=IDLE.
  - rdy, brk, ext, overflow, ack_err, seq, key_code = 0.
  - ack_prev<=ack_toggle.
  - A scan_valid in the same cycle is discarded.
- Reset or clear mid-prefix discards the pending prefix.
- Arithmetic: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is LVL_W bits and saturates only through the full check.

Decomposition:
- Package kbd_mailbox_pkg holds:
  - PFX_EXT=8'hE0, PFX_BRK=8'hF0.
  - Entry struct {ext,brk,code[7:0]}.
  - Status bit index constants.
  - FSM enum {IDLE,GOT_E0,GOT_F0,GOT_E0F0}.
- One sub-module, kbd_code_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on depth and entry width.
- Prefix FSM, presentation register and ack logic live in the top module.

Test Plan:
1. Reset, no stimulus -> key_code=8'h00, code_status=8'h00, fifo_level=0 for 10 cycles.
2. scan 1C at cycle N -> at N+2 key_code=1C, code_status=8'h21. Toggle ack -> next cycle code_status=8'h20.
3. scan E0,F0,74 then ack the prior code -> key_code=74, code_status[2:1]=2'b11, seq=2. Then scan F0,1C -> brk=1, ext=0.
4. Push 10 codes (11..1A) without ack -> key_code=11, fifo_level=8, overflow=1, 1A lost. Nine acks drain 12..19 in order.
5. While full, push a code in the ack cycle -> no overflow, level stays 8. Toggle ack at rdy=0 -> ack_err=1. Assert clear -> all outputs 0, no spurious ack afterwards.
6. Assert clear (or reset) between E0 and 74 -> 74 is presented with ext=0, brk=0.
